raster_timing_decoder: RTL
==========================

# raster_timing_decoder

Receive-side counterpart to the pixel-clock raster counter pair. It consumes a raster stream (data enable, hsync, vsync) on the pixel clock and recovers the pixel column and row of every active pixel. It also measures active line width and frame height, and reports lock once the measured format matches the configured 640x480 geometry for consecutive frames. It sits at the input of any display-capture or overlay path that needs pixel coordinates from a sync stream.

## Interface
- `WIDTH`, 10: bit width of the coordinate and measurement outputs.
- `H_ACTIVE`, 640: expected active pixels per line.
- `V_ACTIVE`, 480: expected active lines per frame.
- `LOCK_FRAMES`, 2: consecutive good frames required to lock.

Ports:
- `clk`  in  1  pixel-domain clock.
- `rst`  in  1  reset; synchronous, active-low.
- `cen`  in  1  pixel enable; all sampling and counting is qualified by it.
- `de`  in  1  active-video enable, active-high.
- `hsync`  in  1  horizontal sync, active-high.
- `vsync`  in  1  vertical sync, active-high.
- `x`  out  WIDTH  column of the current pixel.
- `y`  out  WIDTH  row of the current pixel.
- `pix_valid`  out  1  `x`/`y` describe a valid active pixel.
- `line_start`  out  1  one-cycle pulse on the first pixel of each line.
- `frame_start`  out  1  one-cycle pulse on pixel (0,0).
- `meas_w`  out  WIDTH  pixel count of the last completed line.
- `meas_h`  out  WIDTH  line count of the last completed frame.
- `locked`  out  1  format locked.
- `fmt_err`  out  1  one-cycle pulse when a mismatch is detected while locked.

## Operation
- **Input register and edges.** `de`, `hsync` and `vsync` are registered on each cycle with `cen=1`. Rising and falling edges are detected against the previous registered value.
- **Column counter (`x`).**
  - Cleared to 0 on a `de` rising edge.
  - Increments on each subsequent `cen` cycle while `de` stays high.
  - Saturates at 2^WIDTH-1; saturation marks the line bad.
- **Row counter (`y`).**
  - A `vsync` rising edge arms a first-line flag.
  - The next `de` rising edge sets `y=0` and clears the flag.
  - Every later `de` rising edge increments `y`, saturating at 2^WIDTH-1.
- **Width check.** On a `de` falling edge, `meas_w` latches `x+1`. The line is bad if `x+1 != H_ACTIVE`.
- **Height check.** On a `vsync` rising edge, `meas_h` latches the number of lines seen since the previous `vsync`. The frame is bad if `meas_h != V_ACTIVE` or if any line in it was bad.
- **Simultaneous `vsync` and `de` rising in one sample.** The `vsync` edge is processed first, so that line is row 0 and `frame_start` fires.
- **Lock state machine.**
  - SEARCH: waits for a `vsync` rising edge, then goes to ACQUIRE with the good-frame count at 0.
  - ACQUIRE: at each `vsync` rising edge, a good frame increments the count and a bad frame clears it. When the count reaches `LOCK_FRAMES`, go to LOCKED.
  - LOCKED: a bad line is detected at its `de` falling edge; a bad frame height is detected at the `vsync` rising edge. Either one pulses `fmt_err` and returns to ACQUIRE with the count at 0.
- `locked` is 1 only in LOCKED.

## Timing
- **Reset.** While `rst=0` at a clock edge:
  - all outputs, counters and the input register go to 0;
  - the state goes to SEARCH;
  - the first-line flag is cleared.
  Reset mid-frame discards the partial measurement. Reacquisition starts at the next `vsync` edge.
- **Latency.** A sample accepted with `cen=1` on cycle n is reflected in `x`, `y`, `pix_valid`, `line_start` and `frame_start` on cycle n+1.
- **Pulses.** `line_start`, `frame_start` and `fmt_err` are high for exactly one `clk` cycle and only follow `cen=1` samples.
- **`cen=0`.** Counters, state and measurements hold; all pulses are 0.
- **Lock timing.** `locked` rises one cycle after the `vsync` sample that completes the final good frame. On an error, `locked` falls in the same cycle that `fmt_err` pulses.

## Configuration
- Macro: `RTD_HSYNC_CHECK_EN`.
- **Defined:** every line requires exactly one `hsync` rising edge between its `de` falling edge and the next `de` rising edge, ignoring the vertical blanking gap. Zero or more than one edge marks the following line bad.
- **Undefined:** `hsync` is ignored; the port remains present.

## Structure
- Package `raster_pkg`:
  - state enum `{SEARCH, ACQUIRE, LOCKED}`;
  - default geometry constants 640/480 and WIDTH 10, shared with the raster generator.
- One sub-module, `sync_edge_detect`: a cen-qualified register plus rise/fall pulse outputs, instantiated once per sync input.

## Test plan
- **Mid-frame reset:** hold `rst=0` for 3 cycles mid-frame -> all outputs 0 on the next cycle; no `locked` until 2 full good frames follow a `vsync`.
- **Clean frames:** 3 clean 640x480 frames with `cen=1` -> `meas_w=640`, `meas_h=480`; `locked` rises one cycle after the `vsync` edge that completes the second good frame.
- **Short line while locked:** line 100 carries 639 pixels -> `meas_w=639`, one-cycle `fmt_err`, `locked=0` in the same cycle; relock after 2 further good frames.
- **Throttled enable:** `cen` toggling every other cycle -> identical `x`/`y` sequence to the `cen=1` run; each pulse lasts exactly 1 `clk` cycle.
- **Coincident edges:** `vsync` and `de` rise in the same sample -> `frame_start=1` with `x=0`, `y=0`.
- **Missing hsync:** `hsync` omitted before line 50 while locked -> `fmt_err` pulse with `RTD_HSYNC_CHECK_EN` defined; no error and `locked` held without it.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared raster geometry and lock-FSM encoding for the raster generator/decoder pair.
package raster_pkg;

   localparam int unsigned DEF_WIDTH       = 10;
   localparam int unsigned DEF_H_ACTIVE    = 640;
   localparam int unsigned DEF_V_ACTIVE    = 480;
   localparam int unsigned DEF_LOCK_FRAMES = 2;

   typedef enum logic [1:0] {
      SEARCH,
      ACQUIRE,
      LOCKED
   } lock_state_t;

   // Increment that sticks at max_v instead of wrapping.
   function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Enable-qualified sample register for one sync input with rise/fall pulses
// taken against the previously accepted sample.
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic cen,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic din_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         din_q <= 1'b0;
      end else if (cen) begin
         din_q <= din;
      end
   end

   assign rise = cen & din & ~din_q;
   assign fall = cen & ~din & din_q;

endmodule

// File: rtl/raster_timing_decoder.sv
// Recovers pixel coordinates from a de/hsync/vsync stream, measures line width and
// frame height, and locks onto the configured geometry. Optional hsync check: RTD_HSYNC_CHECK_EN.
module raster_timing_decoder
   import raster_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
   parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
   parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic             de,
   input  logic             hsync,
   input  logic             vsync,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic             pix_valid,
   output logic             line_start,
   output logic             frame_start,
   output logic [WIDTH-1:0] meas_w,
   output logic [WIDTH-1:0] meas_h,
   output logic             locked,
   output logic             fmt_err
);

   localparam int unsigned MAX_VAL = (32'd1 << WIDTH) - 32'd1;
   localparam int unsigned CNT_W   = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

   logic de_rise, de_fall;
   logic hs_rise, hs_fall;
   logic vs_rise, vs_fall;

   sync_edge_detect u_de_edge (
      .clk  (clk),
      .rst  (rst),
      .cen  (cen),
      .din  (de),
      .rise (de_rise),
      .fall (de_fall)
   );

   sync_edge_detect u_hs_edge (
      .clk  (clk),
      .rst  (rst),
      .cen  (cen),
      .din  (hsync),
      .rise (hs_rise),
      .fall (hs_fall)
   );

   sync_edge_detect u_vs_edge (
      .clk  (clk),
      .rst  (rst),
      .cen  (cen),
      .din  (vsync),
      .rise (vs_rise),
      .fall (vs_fall)
   );

   logic             first_q;
   logic             frame_bad_q;
   logic [WIDTH-1:0] line_cnt;
   logic             first_line;
   logic             hs_bad_line;
   logic             line_bad_now;
   logic             height_bad_now;
   logic             frame_bad_now;

   // A vsync edge in the same sample as a de edge makes that line row 0.
   assign first_line = first_q | vs_rise;

   assign line_bad_now   = de_fall & (((32'(x) + 32'd1) != H_ACTIVE) | hs_bad_line);
   assign height_bad_now = vs_rise & (32'(line_cnt) != V_ACTIVE);
   assign frame_bad_now  = height_bad_now | (vs_rise & (frame_bad_q | line_bad_now));

`ifdef RTD_HSYNC_CHECK_EN
   logic [1:0] hs_cnt;
   logic [1:0] hs_total;
   logic       hs_bad_q;
   logic       unused_edges;

   // hs_cnt saturates at 2, which stands for "more than one edge".
   always_comb begin
      hs_total = hs_cnt;
      if (hs_rise && (hs_cnt != 2'd2)) begin
         hs_total = hs_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hs_cnt   <= '0;
         hs_bad_q <= 1'b0;
      end else begin
         if (de_fall) begin
            hs_cnt <= {1'b0, hs_rise};
         end else begin
            hs_cnt <= hs_total;
         end
         if (de_rise) begin
            hs_bad_q <= ~first_line & (hs_total != 2'd1);
         end
      end
   end

   assign hs_bad_line  = hs_bad_q;
   assign unused_edges = hs_fall ^ vs_fall;
`else
   logic unused_edges;

   assign hs_bad_line  = 1'b0;
   assign unused_edges = hs_rise ^ hs_fall ^ vs_fall;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         x           <= '0;
         y           <= '0;
         pix_valid   <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         meas_w      <= '0;
         meas_h      <= '0;
         line_cnt    <= '0;
         first_q     <= 1'b0;
         frame_bad_q <= 1'b0;
      end else begin
         // Edge pulses are already cen-qualified, so these drop to 0 on idle cycles.
         line_start  <= de_rise;
         frame_start <= de_rise & first_line;
         if (cen) begin
            pix_valid <= de;
            if (de_rise) begin
               x <= '0;
            end else if (de) begin
               x <= WIDTH'(sat_inc(32'(x), MAX_VAL));
            end
            if (de_rise) begin
               if (first_line) begin
                  y <= '0;
               end else begin
                  y <= WIDTH'(sat_inc(32'(y), MAX_VAL));
               end
            end
            if (de_rise) begin
               first_q <= 1'b0;
            end else if (vs_rise) begin
               first_q <= 1'b1;
            end
            if (de_fall) begin
               meas_w <= WIDTH'(sat_inc(32'(x), MAX_VAL));
            end
            if (vs_rise) begin
               meas_h      <= line_cnt;
               line_cnt    <= de_rise ? WIDTH'(1) : '0;
               frame_bad_q <= 1'b0;
            end else begin
               if (de_rise) begin
                  line_cnt <= WIDTH'(sat_inc(32'(line_cnt), MAX_VAL));
               end
               if (line_bad_now) begin
                  frame_bad_q <= 1'b1;
               end
            end
         end
      end
   end

   lock_state_t      state;
   logic [CNT_W-1:0] good_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= SEARCH;
         good_cnt <= '0;
         locked   <= 1'b0;
         fmt_err  <= 1'b0;
      end else begin
         fmt_err <= 1'b0;
         case (state)
            SEARCH: begin
               if (vs_rise) begin
                  state    <= ACQUIRE;
                  good_cnt <= '0;
               end
            end
            ACQUIRE: begin
               if (vs_rise) begin
                  if (frame_bad_now) begin
                     good_cnt <= '0;
                  end else if ((32'(good_cnt) + 32'd1) >= LOCK_FRAMES) begin
                     state    <= LOCKED;
                     locked   <= 1'b1;
                     good_cnt <= '0;
                  end else begin
                     good_cnt <= good_cnt + 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (line_bad_now || height_bad_now) begin
                  state    <= ACQUIRE;
                  locked   <= 1'b0;
                  fmt_err  <= 1'b1;
                  good_cnt <= '0;
               end
            end
            default: begin
               state    <= SEARCH;
               locked   <= 1'b0;
               good_cnt <= '0;
            end
         endcase
      end
   end

endmodule
